phy_lanes: RTL and testbench

PHY_LANES -- requirements
Module: phy_lanes

---
 rtl/phy_lanes.sv | 148 ++++++++++++++
 tb/tb_phy_lanes.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_lanes.sv
// Per-lane symbol mux for the main link: normal data with per-lane skew, TPS1, TPS2, PRBS7.
// Latency: one dpclk from selection to txdat/txisk; lane i data path adds i*SKEW delay stages.
// No backpressure: a new word is produced every dpclk, the serialisers always accept it.
module phy_lanes #(
  parameter int LANES = 4,
  parameter int SKEW  = 2
) (
  input  logic                 dpclk,
  input  logic                 rstn,
  input  logic [2:0]           phymode,
  input  logic [1:0]           lanecnt,
  input  logic [16*LANES-1:0]  scrdat,
  input  logic [2*LANES-1:0]   scrisk,
  output logic [16*LANES-1:0]  txdat,
  output logic [2*LANES-1:0]   txisk
);

  localparam logic [15:0] SYM_D10 = 16'h4A4A;
  localparam logic [15:0] SYM_K28 = 16'hCBBC;
  localparam logic [6:0]  SEED    = 7'h7F;

  // Reset synchroniser: asserts immediately, releases on the second dpclk edge.
  logic [1:0] rst_sync;
  logic       srst_n;

  // Release reset synchronously so the first live edge sees a clean mode entry.
  always_ff @(posedge dpclk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign srst_n = rst_sync[1];

  logic [2:0]  mode_q;
  logic [2:0]  cnt;
  logic [6:0]  lfsr;
  logic        entry;
  logic [2:0]  cnt_eff;
  logic [6:0]  st;
  logic        nb;
  logic [6:0]  lfsr_nxt;
  logic [15:0] prbs_word;
  int          act;
  logic [17:0] lane_tap [LANES];
  logic [16*LANES-1:0] nxt_dat;
  logic [2*LANES-1:0]  nxt_isk;

  // A mode change (including the first edge after reset) restarts the pattern generators.
  assign entry   = (phymode != mode_q);
  assign cnt_eff = entry ? 3'd0 : cnt;

  // Per-lane skew delay lines; they shift in every mode so history is always current.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = i * SKEW;
    logic [17:0] din;
    assign din = {scrisk[2*i +: 2], scrdat[16*i +: 16]};
    if (D == 0) begin : g_direct
      assign lane_tap[i] = din;
    end else begin : g_dly
      logic [17:0] sr [D];
      // Shift register of depth i*SKEW, cleared by reset.
      always_ff @(posedge dpclk or negedge srst_n) begin
        if (!srst_n) begin
          for (int k = 0; k < D; k++) sr[k] <= '0;
        end else begin
          sr[0] <= din;
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      assign lane_tap[i] = sr[D-1];
    end
  end

  // Generate the next 16 PRBS7 bits (x^7+x^6+1), bit 0 first; restart from seed on entry.
  always_comb begin
    nb        = 1'b0;
    prbs_word = '0;
    st        = entry ? SEED : lfsr;
    for (int k = 0; k < 16; k++) begin
      nb           = st[6] ^ st[5];
      prbs_word[k] = nb;
      st           = {st[5:0], nb};
    end
    lfsr_nxt = st;
  end

  // Active lane count from lanecnt, clipped to the lanes actually built.
  always_comb begin
    case (lanecnt)
      2'd0:    act = 1;
      2'd1:    act = 2;
      default: act = 4;
    endcase
    if (act > LANES) act = LANES;
  end

  // Select the symbols for every lane; inactive lanes and off modes send zero.
  always_comb begin
    nxt_dat = '0;
    nxt_isk = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < act) begin
        case (phymode)
          3'd1: begin
            nxt_dat[16*i +: 16] = lane_tap[i][15:0];
            nxt_isk[2*i +: 2]   = lane_tap[i][17:16];
          end
          3'd2: nxt_dat[16*i +: 16] = SYM_D10;
          3'd3: begin
            if (cnt_eff < 3'd2) begin
              nxt_dat[16*i +: 16] = SYM_K28;
              nxt_isk[2*i +: 2]   = 2'b01;
            end else begin
              nxt_dat[16*i +: 16] = SYM_D10;
            end
          end
          3'd4: nxt_dat[16*i +: 16] = prbs_word;
          default: ;
        endcase
      end
    end
  end

  // Mode tracking and pattern state; generators hold while their mode is not selected.
  always_ff @(posedge dpclk or negedge srst_n) begin
    if (!srst_n) begin
      mode_q <= 3'd0;
      cnt    <= 3'd0;
      lfsr   <= SEED;
    end else begin
      mode_q <= phymode;
      if (phymode == 3'd3) cnt <= (cnt_eff == 3'd4) ? 3'd0 : cnt_eff + 3'd1;
      if (phymode == 3'd4) lfsr <= lfsr_nxt;
    end
  end

  // Output register: one word per dpclk, whole word from a single mode decision.
  always_ff @(posedge dpclk or negedge srst_n) begin
    if (!srst_n) begin
      txdat <= '0;
      txisk <= '0;
    end else begin
      txdat <= nxt_dat;
      txisk <= nxt_isk;
    end
  end

endmodule

// File: tb/tb_phy_lanes.sv
// Self-checking bench for phy_lanes: randomized stimulus against a queue-based reference model.
// Expected words are computed one step ahead and compared at the following falling edge.
// Pattern sequences are modelled from cycles-since-entry and a PRBS bit recurrence.
module tb_phy_lanes;
  localparam int LANES = 4;
  localparam int SKEW  = 2;

  logic                dpclk = 1'b0;
  logic                rstn  = 1'b1;
  logic [2:0]          phymode = 3'd0;
  logic [1:0]          lanecnt = 2'd2;
  logic [16*LANES-1:0] scrdat = '0;
  logic [2*LANES-1:0]  scrisk = '0;
  logic [16*LANES-1:0] txdat;
  logic [2*LANES-1:0]  txisk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [16*LANES-1:0] hd[$];
  logic [2*LANES-1:0]  hk[$];
  logic [2:0]          prev_mode;
  int                  since3;
  bit                  prbs_q[$];
  logic [16*LANES-1:0] exp_dat;
  logic [2*LANES-1:0]  exp_isk;
  int                  stepn = 0;

  phy_lanes #(.LANES(LANES), .SKEW(SKEW)) dut (
    .dpclk(dpclk), .rstn(rstn), .phymode(phymode), .lanecnt(lanecnt),
    .scrdat(scrdat), .scrisk(scrisk), .txdat(txdat), .txisk(txisk)
  );

  always #5 dpclk = ~dpclk;

  function automatic int active_lanes(input logic [1:0] lc);
    int a;
    a = (lc == 2'd0) ? 1 : (lc == 2'd1) ? 2 : 4;
    return (a > LANES) ? LANES : a;
  endfunction

  // Compute the word the current inputs should produce, then advance one clock.
  task automatic tick();
    logic [15:0] pw;
    bit          entry;
    int          act;
    int          idx;
    bit          nbit;
    hd.push_back(scrdat);
    hk.push_back(scrisk);
    entry = (phymode != prev_mode);
    pw = '0;
    if (phymode == 3'd3 && entry) since3 = 0;
    if (phymode == 3'd4) begin
      if (entry) begin
        prbs_q = {};
        repeat (7) prbs_q.push_back(1'b1);
      end
      for (int b = 0; b < 16; b++) begin
        nbit = prbs_q[0] ^ prbs_q[1];
        prbs_q.push_back(nbit);
        void'(prbs_q.pop_front());
        pw[b] = nbit;
      end
    end
    act = active_lanes(lanecnt);
    exp_dat = '0;
    exp_isk = '0;
    for (int i = 0; i < act; i++) begin
      case (phymode)
        3'd1: begin
          idx = hd.size() - 1 - i * SKEW;
          if (idx >= 0) begin
            exp_dat[16*i +: 16] = hd[idx][16*i +: 16];
            exp_isk[2*i +: 2]   = hk[idx][2*i +: 2];
          end
        end
        3'd2: exp_dat[16*i +: 16] = 16'h4A4A;
        3'd3: begin
          if ((since3 % 5) < 2) begin
            exp_dat[16*i +: 16] = 16'hCBBC;
            exp_isk[2*i +: 2]   = 2'b01;
          end else begin
            exp_dat[16*i +: 16] = 16'h4A4A;
          end
        end
        3'd4: exp_dat[16*i +: 16] = pw;
        default: ;
      endcase
    end
    if (phymode == 3'd3) since3++;
    prev_mode = phymode;
    stepn++;
    @(negedge dpclk);
  endtask

  task automatic model_clear();
    hd = {};
    hk = {};
    prev_mode = 3'd0;
    since3 = 0;
    prbs_q = {};
  endtask

  task automatic randomize_data();
    for (int i = 0; i < LANES; i++) begin
      scrdat[16*i +: 16] = 16'($urandom);
      scrisk[2*i +: 2]   = 2'($urandom);
    end
  endtask

  // Clean reset from a falling edge; leaves the design idle in mode 0 with zero history.
  task automatic test_reset();
    @(negedge dpclk);
    phymode = 3'd0; lanecnt = 2'd2; scrdat = '0; scrisk = '0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({txisk, txdat} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h/%h exp=0/0", txisk, txdat);
    end
    @(negedge dpclk);
    checks++;
    if ({txisk, txdat} !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h/%h exp=0/0", txisk, txdat);
    end
    rstn = 1'b1;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
  endtask

  // Mode 1 with a per-lane ramp, then random data; lane i lags by 1+i*SKEW.
  task automatic test_normal();
    phymode = 3'd1; lanecnt = 2'd2;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < LANES; i++) begin
        scrdat[16*i +: 16] = 16'(i * 16'h1111 + c);
        scrisk[2*i +: 2]   = 2'(c + i);
      end
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL normal_ramp c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
    if (txdat[63:48] !== 16'(3 * 16'h1111 + 23 - 6)) begin
      failures++;
      $display("FAIL normal_lane3_lag got=%h exp=%h", txdat[63:48], 16'(3 * 16'h1111 + 17));
    end
    checks++;
    for (int c = 0; c < 16; c++) begin
      randomize_data();
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL normal_rand c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
  endtask

  // TPS2 held for 12 words, then a 2->3 switch mid-stream must restart at CBBC.
  task automatic test_tps2();
    lanecnt = 2'd2;
    phymode = 3'd3;
    for (int c = 0; c < 12; c++) begin
      randomize_data();
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL tps2_run c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
    phymode = 3'd2;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL tps1_run c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
    phymode = 3'd3;
    tick();
    checks++;
    if (txdat[15:0] !== 16'hCBBC || txisk[1:0] !== 2'b01) begin
      failures++;
      $display("FAIL tps2_restart got=%h/%h exp=01/cbbc", txisk[1:0], txdat[15:0]);
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL tps2_after c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
  endtask

  // PRBS7 from entry: golden first word, then model comparison over a full period.
  task automatic test_prbs();
    phymode = 3'd0;
    tick();
    phymode = 3'd4; lanecnt = 2'd3;
    tick();
    checks++;
    if (txdat[15:0] !== 16'h3040 || txisk !== '0) begin
      failures++;
      $display("FAIL prbs_first got=%h/%h exp=00/3040", txisk, txdat[15:0]);
    end
    for (int c = 0; c < 10; c++) begin
      randomize_data();
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL prbs_word c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
  endtask

  // Single-lane operation in every active mode.
  task automatic test_lanecnt0();
    for (int m = 1; m <= 4; m++) begin
      phymode = 3'(m); lanecnt = 2'd0;
      for (int c = 0; c < 8; c++) begin
        randomize_data();
        tick();
        checks++;
        if (txdat !== exp_dat || txisk !== exp_isk || txdat[63:16] !== '0) begin
          failures++;
          $display("FAIL lanecnt0 m=%0d c=%0d got=%h/%h exp=%h/%h", m, c, txisk, txdat, exp_isk, exp_dat);
        end
      end
    end
  endtask

  // Off modes then TPS1 on the very next word.
  task automatic test_off();
    lanecnt = 2'd2;
    phymode = 3'd7;
    for (int c = 0; c < 4; c++) begin
      randomize_data();
      tick();
      checks++;
      if (txdat !== '0 || txisk !== '0) begin
        failures++;
        $display("FAIL off7 c=%0d got=%h/%h exp=0/0", c, txisk, txdat);
      end
    end
    phymode = 3'd0;
    for (int c = 0; c < 3; c++) begin
      randomize_data();
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL off0 c=%0d got=%h/%h exp=%h/%h", c, txisk, txdat, exp_isk, exp_dat);
      end
    end
    phymode = 3'd2;
    tick();
    checks++;
    if (txdat !== {4{16'h4A4A}} || txisk !== '0) begin
      failures++;
      $display("FAIL off_to_tps1 got=%h/%h exp=00/4a4a4a4a4a4a4a4a", txisk, txdat);
    end
  endtask

  // Random mode, lanecnt and data, including changes on arbitrary cycles.
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 5) == 0) phymode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) lanecnt = 2'($urandom);
      randomize_data();
      tick();
      checks++;
      if (txdat !== exp_dat || txisk !== exp_isk) begin
        failures++;
        $display("FAIL random c=%0d mode=%0d lc=%0d got=%h/%h exp=%h/%h",
                 c, phymode, lanecnt, txisk, txdat, exp_isk, exp_dat);
      end
    end
  endtask

  // Reset pulse while TPS2 sits at counter 3; pattern restarts with two CBBC words.
  task automatic test_reset_mid();
    logic [16*LANES-1:0] k_word;
    int waited;
    phymode = 3'd0; lanecnt = 2'd2;
    tick();
    phymode = 3'd3;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({txisk, txdat} !== '0) begin
      failures++;
      $display("FAIL midreset_async got=%h/%h exp=0/0", txisk, txdat);
    end
    @(negedge dpclk);
    checks++;
    if ({txisk, txdat} !== '0) begin
      failures++;
      $display("FAIL midreset_hold got=%h/%h exp=0/0", txisk, txdat);
    end
    rstn = 1'b1;
    waited = 0;
    @(negedge dpclk);
    while (txdat == '0 && waited < 5) begin
      @(negedge dpclk);
      waited++;
    end
    k_word = {4{16'hCBBC}};
    checks++;
    if (txdat !== k_word || txisk !== 8'h55) begin
      failures++;
      $display("FAIL midreset_first got=%h/%h exp=55/%h waited=%0d", txisk, txdat, k_word, waited);
    end
    @(negedge dpclk);
    checks++;
    if (txdat !== k_word || txisk !== 8'h55) begin
      failures++;
      $display("FAIL midreset_second got=%h/%h exp=55/%h", txisk, txdat, k_word);
    end
    @(negedge dpclk);
    checks++;
    if (txdat !== {4{16'h4A4A}} || txisk !== 8'h00) begin
      failures++;
      $display("FAIL midreset_third got=%h/%h exp=00/4a4a4a4a4a4a4a4a", txisk, txdat);
    end
  endtask

  initial begin
    model_clear();
    #3 rstn = 1'b0;
    #2;
    checks++;
    if ({txisk, txdat} !== '0) begin
      failures++;
      $display("FAIL power_on_reset got=%h/%h exp=0/0", txisk, txdat);
    end
    rstn = 1'b1;
    test_reset();
    test_normal();
    test_tps2();
    test_prbs();
    test_lanecnt0();
    test_off();
    test_random();
    test_reset_mid();
    test_reset();
    test_tps2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends with a summary.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
